// File: rtl/branch_sequencer.sv
// Multi-cycle control sequencer for conditional branches on the single-bus datapath:
// fetch, drive the condition flip-flop, then conditionally load PC with PC + offset.
// state | meaning
// IDLE  | waiting for start          T0-T2 | fetch (T1W waits on mem_ready)
// T3    | opcode check, CON strobe   T4-T6 | capture condition, PC + offset
// DONE  | done pulse, illegal on abort
module branch_sequencer #(
    parameter logic [4:0]  BR_OPCODE   = 5'b10010,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TW          = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        con_q,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        taken,
    output logic [1:0]  cond_sel,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Gra,
    output logic        Rout,
    output logic        CONin,
    output logic        Yin,
    output logic        Cout,
    output logic        ADD
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_t;

    localparam logic [TW-1:0] WAIT_MAX = TW'(MEM_TIMEOUT);

    state_t        state_q, state_d;
    logic          taken_q, taken_d;
    logic          err_q, err_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          op_ok;
    logic          ir_unused;

    assign op_ok = (ir[31:27] == BR_OPCODE);
    // Only the opcode and condition-select fields matter to the sequencer.
    assign ir_unused = ^{ir[26:21], ir[18:0]};

    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        err_d   = err_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_T0;
                    taken_d = 1'b0;
                    err_d   = 1'b0;
                    wait_d  = '0;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T1W;
            S_T1W: begin
                if (mem_ready) begin
                    state_d = S_T2;
                end else if (wait_q == WAIT_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                if (op_ok) begin
                    state_d = S_T4;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_T4: begin
                taken_d = con_q;
                state_d = S_T5;
            end
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        illegal  = 1'b0;
        taken    = taken_q;
        cond_sel = 2'b00;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Gra      = 1'b0;
        Rout     = 1'b0;
        CONin    = 1'b0;
        Yin      = 1'b0;
        Cout     = 1'b0;
        ADD      = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
            end
            S_T1W: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                cond_sel = ir[20:19];
                Gra      = op_ok;
                Rout     = op_ok;
                CONin    = op_ok;
            end
            S_T4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            S_T5: begin
                Cout = 1'b1;
                ADD  = 1'b1;
                Zin  = 1'b1;
            end
            S_T6: begin
                Zlowout = 1'b1;
                PCin    = taken_q;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a per-cycle schedule of expected outputs is
// built from each transaction's parameters and compared on every falling edge.
module tb_branch_sequencer;

    localparam logic [4:0] BR = 5'b10010;
    localparam int         TMO = 15;

    localparam logic [15:0] M_PCOUT = 16'h8000, M_MARIN = 16'h4000, M_INCPC = 16'h2000,
                            M_ZIN = 16'h1000, M_ZLOW = 16'h0800, M_PCIN = 16'h0400,
                            M_READ = 16'h0200, M_MDRIN = 16'h0100, M_MDROUT = 16'h0080,
                            M_IRIN = 16'h0040, M_GRA = 16'h0020, M_ROUT = 16'h0010,
                            M_CONIN = 16'h0008, M_YIN = 16'h0004, M_COUT = 16'h0002,
                            M_ADD = 16'h0001;

    logic        clk = 1'b0;
    logic        clr, start, mem_ready, con_q;
    logic [31:0] ir;
    logic        busy, done, illegal, taken;
    logic [1:0]  cond_sel;
    logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
    logic        MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD;

    branch_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_ready(mem_ready), .con_q(con_q),
        .busy(busy), .done(done), .illegal(illegal), .taken(taken), .cond_sel(cond_sel),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
        .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Gra(Gra), .Rout(Rout), .CONin(CONin), .Yin(Yin), .Cout(Cout), .ADD(ADD)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    int          last_done_cyc = -1;
    logic        idle_taken = 1'b0;
    logic [21:0] exp_q[$];
    logic [21:0] act;

    assign act = {busy, done, illegal, taken, cond_sel,
                  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
                  MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD};

    always @(posedge clk) cyc++;

    function automatic logic [21:0] vec(input logic bz, input logic dn, input logic il,
                                        input logic tk, input logic [1:0] cs,
                                        input logic [15:0] s);
        return {bz, dn, il, tk, cs, s};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [1:0] cs);
        return {op, 6'h15, cs, 19'h2B3C5};
    endfunction

    // Expected outputs for every cycle from T0 through DONE of one transaction.
    task automatic push_seq(input int waits, input logic legal, input logic con,
                            input logic [1:0] cs);
        bit tmo;
        tmo = (waits > TMO);
        exp_q.push_back(vec(1, 0, 0, 0, 2'b00, M_PCOUT | M_MARIN | M_INCPC | M_ZIN));
        exp_q.push_back(vec(1, 0, 0, 0, 2'b00, M_ZLOW | M_PCIN | M_READ));
        for (int i = 0; i < (tmo ? TMO + 1 : waits + 1); i++)
            exp_q.push_back(vec(1, 0, 0, 0, 2'b00, M_READ | M_MDRIN));
        if (tmo) begin
            exp_q.push_back(vec(1, 1, 1, 0, 2'b00, 16'h0));
            idle_taken = 1'b0;
        end else begin
            exp_q.push_back(vec(1, 0, 0, 0, 2'b00, M_MDROUT | M_IRIN));
            if (!legal) begin
                exp_q.push_back(vec(1, 0, 0, 0, cs, 16'h0));
                exp_q.push_back(vec(1, 1, 1, 0, 2'b00, 16'h0));
                idle_taken = 1'b0;
            end else begin
                exp_q.push_back(vec(1, 0, 0, 0, cs, M_GRA | M_ROUT | M_CONIN));
                exp_q.push_back(vec(1, 0, 0, 0, 2'b00, M_PCOUT | M_YIN));
                exp_q.push_back(vec(1, 0, 0, con, 2'b00, M_COUT | M_ADD | M_ZIN));
                exp_q.push_back(vec(1, 0, 0, con, 2'b00, M_ZLOW | (con ? M_PCIN : 16'h0)));
                exp_q.push_back(vec(1, 1, 0, con, 2'b00, 16'h0));
                idle_taken = con;
            end
        end
    endtask

    task automatic check(input string nm, input int got, input int want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s got %0d expected %0d", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        logic [21:0] e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = vec(0, 0, 0, idle_taken, 2'b00, 16'h0);
        nvec++;
        if (act !== e) begin
            nerr++;
            $display("FAIL outputs cycle %0d got %h expected %h", cyc, act, e);
        end
        if (done === 1'b1) last_done_cyc = cyc;
    end

    // One transaction; lat is the hand-computed start-to-done latency.
    task automatic run_seq(input string nm, input int waits, input logic [4:0] op,
                           input logic [1:0] cs, input logic con, input int lat);
        int k;
        @(posedge clk); #1;
        k = cyc;
        start = 1'b1;
        ir = mk_ir(op, cs);
        con_q = con;
        @(posedge clk); #1;
        start = 1'b0;
        push_seq(waits, op == BR, con, cs);
        check({nm, "_sched_len"}, exp_q.size(), lat);
        while (cyc < k + lat + 1) begin
            mem_ready = (cyc >= k + 3 + waits);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        check({nm, "_latency"}, last_done_cyc - k, lat);
        check({nm, "_taken"}, int'(taken), int'(con && op == BR && waits <= TMO));
    endtask

    initial begin
        int k;
        clr = 1'b0; start = 1'b0; ir = '0; mem_ready = 1'b1; con_q = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        repeat (2) @(posedge clk);

        run_seq("taken",     0, BR,       2'b01, 1'b1, 9);
        run_seq("not_taken", 0, BR,       2'b01, 1'b0, 9);
        run_seq("mem_wait",  3, BR,       2'b10, 1'b1, 12);
        run_seq("timeout",  99, BR,       2'b11, 1'b1, 19);
        run_seq("illegal",   0, 5'b00011, 2'b10, 1'b1, 6);

        // start held high through DONE: retriggers only from the following IDLE cycle
        @(posedge clk); #1;
        k = cyc;
        start = 1'b1;
        ir = mk_ir(5'b00011, 2'b01);
        @(posedge clk); #1;
        push_seq(0, 1'b0, 1'b0, 2'b01);
        exp_q.push_back(vec(0, 0, 0, 0, 2'b00, 16'h0));
        push_seq(0, 1'b0, 1'b0, 2'b01);
        check("hold_sched_len", exp_q.size(), 13);
        while (cyc < k + 8) begin @(posedge clk); #1; end
        start = 1'b0;
        while (cyc < k + 14) begin @(posedge clk); #1; end
        check("hold_latency", last_done_cyc - k, 13);

        // asynchronous reset while in T5 of a taken branch
        @(posedge clk); #1;
        k = cyc;
        start = 1'b1;
        ir = mk_ir(BR, 2'b11);
        con_q = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_seq(0, 1'b1, 1'b1, 2'b11);
        while (cyc < k + 7) begin @(posedge clk); #1; end
        check("pre_reset_taken", int'(taken), 1);
        clr = 1'b0;
        exp_q.delete();
        idle_taken = 1'b0;
        #1 check("reset_busy", int'(busy), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;
        run_seq("after_reset", 0, BR, 2'b01, 1'b1, 9);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
